// File: rtl/async_fifo_reader_pkg.sv
// Shared types and sizing for the async_fifo read-side burst controller.
package async_fifo_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } rd_state_e;

   localparam int BUF_DEPTH    = 4;
   localparam int MAX_INFLIGHT = 2;

   // occ counts 0..BUF_DEPTH, inflight counts 0..MAX_INFLIGHT
   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int OCC_W = $clog2(BUF_DEPTH + 1);
   localparam int INF_W = $clog2(MAX_INFLIGHT + 1);

endpackage

// File: rtl/rd_out_buf.sv
// Small single-clock output buffer between the FIFO read port and the
// downstream valid/ready stream. Head word is shown combinationally.
module rd_out_buf
   import async_fifo_reader_pkg::*;
#(
   parameter int d_width = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               push,
   input  logic [d_width-1:0] push_data,
   input  logic               pop,
   output logic [OCC_W-1:0]   occ,
   output logic               out_valid_o,
   output logic [d_width-1:0] out_data_o
);

   logic [d_width-1:0] mem [BUF_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;

   // storage, pointers and occupancy; the issuer never pushes into a full
   // buffer and the top only pops while valid
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   occ <= occ + OCC_W'(1);
            2'b01:   occ <= occ - OCC_W'(1);
            default: occ <= occ;
         endcase
      end
   end

   // data forced to 0 while empty so nothing stale is visible after reset
   always_comb begin
      out_valid_o = (occ != '0);
      out_data_o  = out_valid_o ? mem[rd_ptr] : '0;
   end

endmodule

// File: rtl/async_fifo_reader.sv
// Read-side burst controller for async_fifo (rd_clk domain). Issues a
// programmed number of reads, absorbs the FIFO's one-cycle read latency and
// hands words downstream through a 4-entry buffer.
module async_fifo_reader
   import async_fifo_reader_pkg::*;
#(
   parameter int d_width = 8,
   parameter int len_w   = 4
) (
   input  logic               rd_clk,
   input  logic               reset,
   input  logic               start_i,
   input  logic [len_w-1:0]   len_i,
   input  logic               fifo_empty_i,
   input  logic [d_width-1:0] fifo_rd_data_i,
   output logic               fifo_rd_en_o,
   output logic               out_valid_o,
   output logic [d_width-1:0] out_data_o,
   input  logic               out_ready_i,
   output logic               busy_o,
   output logic               done_o
);

   rd_state_e          state, state_nxt;
   logic [len_w-1:0]   remaining;
   logic [len_w-1:0]   to_deliver;
   logic [OCC_W-1:0]   occ;
   logic [INF_W-1:0]   inflight;
   logic               cap_vld;
   logic [OCC_W:0]     pending;
   logic               start_ok;
   logic               xfer;
   logic               last_issue;
   logic               last_xfer;

   // buffer slots already spoken for: words held plus words still in flight
   assign pending    = (OCC_W+1)'(occ) + (OCC_W+1)'(inflight);
   assign start_ok   = start_i && (len_i != '0);
   assign xfer       = out_valid_o && out_ready_i;
   assign last_issue = fifo_rd_en_o && (remaining == len_w'(1));
   assign last_xfer  = xfer && (to_deliver == len_w'(1));

   // state register
   always_ff @(posedge rd_clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start_ok)   state_nxt = ST_READ;
         ST_READ:  if (last_issue) state_nxt = ST_DRAIN;
         ST_DRAIN: if (last_xfer)  state_nxt = ST_DONE;
         ST_DONE:                  state_nxt = ST_IDLE;
         default:                  state_nxt = ST_IDLE;
      endcase
   end

   // outputs decoded from state; read issue also throttled by buffer space
   always_comb begin
      busy_o       = (state != ST_IDLE);
      done_o       = (state == ST_DONE);
      fifo_rd_en_o = (state == ST_READ) && !fifo_empty_i &&
                     (remaining != '0) && (pending < (OCC_W+1)'(BUF_DEPTH));
   end

   // burst counters: loaded on an accepted start, stepped per issue/transfer
   always_ff @(posedge rd_clk) begin
      if (reset) begin
         remaining  <= '0;
         to_deliver <= '0;
      end else if (state == ST_IDLE) begin
         if (start_ok) begin
            remaining  <= len_i;
            to_deliver <= len_i;
         end
      end else begin
         if (fifo_rd_en_o) remaining  <= remaining - len_w'(1);
         if (xfer)         to_deliver <= to_deliver - len_w'(1);
      end
   end

   // read-latency tracking: a read issued this cycle is captured next cycle;
   // reset drops any word still in flight
   always_ff @(posedge rd_clk) begin
      if (reset) begin
         cap_vld  <= 1'b0;
         inflight <= '0;
      end else begin
         cap_vld  <= fifo_rd_en_o;
         inflight <= inflight + INF_W'(fifo_rd_en_o) - INF_W'(cap_vld);
      end
   end

   rd_out_buf #(.d_width(d_width)) u_buf (
      .clk         (rd_clk),
      .reset       (reset),
      .push        (cap_vld),
      .push_data   (fifo_rd_data_i),
      .pop         (xfer),
      .occ         (occ),
      .out_valid_o (out_valid_o),
      .out_data_o  (out_data_o)
   );

endmodule

// File: doc/async_fifo_reader.md
# async_fifo_reader

Read-side burst controller for `async_fifo`, running entirely in the `rd_clk` domain. On a start command it reads a programmed number of words through the FIFO's `rd_en`/`empty_o`/`rd_data` port. It absorbs the FIFO's one-cycle registered read latency and delivers the words downstream on a valid/ready stream through a 4-entry output buffer. It is the consumer counterpart to the write-side traffic that fills the FIFO.

## Interface
- `d_width`, 8, data word width; must match the FIFO.
- `len_w`, 4, burst-length field width; bursts are 1..2^len_w-1 words.
- `rd_clk`  in  1  sole clock; FIFO read clock.
- `reset`  in  1  synchronous, active-high reset, sampled on `rd_clk` rising edge.
- `start_i`  in  1  one-cycle burst request; sampled only in IDLE.
- `len_i`  in  len_w  burst length, captured with `start_i`.
- `fifo_empty_i`  in  1  FIFO `empty_o`.
- `fifo_rd_data_i`  in  d_width  FIFO `rd_data`; valid the cycle after `fifo_rd_en_o`.
- `fifo_rd_en_o`  out  1  FIFO `rd_en`; combinational from registered state and `fifo_empty_i`.
- `out_valid_o`  out  1  output word available.
- `out_data_o`  out  d_width  head of output buffer.
- `out_ready_i`  in  1  downstream accept.
- `busy_o`  out  1  high in every state except IDLE.
- `done_o`  out  1  one-cycle pulse when the last word of a burst is accepted downstream.

## Operation
- FSM states:
  - IDLE: on `start_i && len_i != 0`, latch `len_i` into `remaining` and `to_deliver`, go to READ. `start_i` with `len_i == 0` is ignored.
  - READ: issue reads. When `remaining` reaches 0 after an issue, go to DRAIN.
  - DRAIN: no reads issued. When the last word is accepted (`to_deliver` reaches 0), go to DONE.
  - DONE: `done_o = 1` for one cycle, then go to IDLE.
- Read issue: `fifo_rd_en_o = (state==READ) && !fifo_empty_i && remaining != 0 && (occ + inflight) < 4`.
  - `occ` is the output-buffer occupancy (0..4).
  - `inflight` is the number of reads issued but not yet captured (0..2).
- Capture: a read issued in cycle c puts its word on `fifo_rd_data_i` in cycle c+1. The word is written into the buffer at the end of cycle c+1.
- Output handshake: a transfer occurs when `out_valid_o && out_ready_i`. Each transfer decrements `to_deliver`. `out_data_o` holds stable while valid and not ready.
- Buffer ordering: strict FIFO order; no words are dropped or duplicated.
- `start_i` while `busy_o` is ignored; no queuing.
- Reset at any point forces the following, and the in-flight FIFO word is discarded:
  - state IDLE
  - `occ = inflight = remaining = to_deliver = 0`
  - all outputs 0
- Counter widths: `remaining` and `to_deliver` are len_w bits; `occ` is 3 bits; `inflight` is 2 bits. No counter wraps under legal operation.

## Timing
- Reset values: `fifo_rd_en_o = 0`, `out_valid_o = 0`, `out_data_o = 0`, `busy_o = 0`, `done_o = 0`.
- `start_i` sampled at edge e → state READ from cycle e+1. The first `fifo_rd_en_o` can assert in that cycle.
- Latency from `fifo_rd_en_o` (cycle c) to `out_valid_o` is 2 cycles (cycle c+2) when the buffer was empty.
- Throughput: one word per cycle when FIFO is non-empty and `out_ready_i = 1` continuously.
- Backpressure: with `out_ready_i = 0`, at most 4 words are buffered, after which reads stop. Reads resume the cycle after `occ + inflight` drops below 4.
- FIFO empty: reads stall while `fifo_empty_i = 1` and resume in the same cycle `empty_o` deasserts. The burst remains open indefinitely.
- `done_o` pulses the cycle after the final transfer. `busy_o` falls one cycle later.
- Earliest new `start_i` accepted: the first cycle in IDLE.

## Structure
- Package `async_fifo_reader_pkg` contains:
  - state enum (IDLE, READ, DRAIN, DONE)
  - `BUF_DEPTH = 4`
  - `MAX_INFLIGHT = 2`
- Sub-module `rd_out_buf`: 4-entry single-clock synchronous FIFO (push/pop, `occ` output, `out_valid_o` = non-empty). The top holds the FSM, the counters and the issue logic.

## Test plan
- Reset held 3 cycles, then released → all outputs 0; `start_i` during reset produces no `fifo_rd_en_o`.
- FIFO preloaded with 45, 23, 27, 22, 12; `start_i` with `len_i = 5`; `out_ready_i = 1` → five consecutive `fifo_rd_en_o` cycles; outputs 45, 23, 27, 22, 12 on consecutive cycles starting 2 cycles after the first read; one `done_o` pulse.
- Same preload, `out_ready_i = 0` for 10 cycles → exactly 4 reads issued, `out_data_o` = 45 held stable; after release, the remaining read is issued and all 5 words arrive in order.
- FIFO holds 2 words, `len_i = 4`; 2 more words written 10 cycles later → read stalls while empty; 4 words delivered; `done_o` only after the 4th transfer.
- `start_i` pulsed mid-burst with `len_i = 3` → ignored; only the original burst count is delivered.
- Reset asserted during READ with 2 words buffered → next cycle all outputs 0 and state IDLE; a new burst of 2 words delivers the next FIFO words with no stale data.
